// File: rtl/int_seq.sv
// ---------------------------------------------------------------------------
// int_seq -- interrupter sequencer for the DRSSTC controller.
//
// Sits in front of the interrupter generator and owns its freq_par / pw_par
// inputs. The pulse-width code is soft-started toward the operator target at
// one LSB per ramp tick and is clamped to PW_MAX. A fault mutes the
// interrupter (pw_par = 0) on the next edge and holds it in LOCK for at least
// LOCK_CYC clocks. The operator must then drop en before the block re-arms.
//
// Optional feature (compile-time macro INT_SEQ_RAMP_DOWN_EN):
//   defined   - dropping en ramps pw_par down to 0 at one step per tick
//               (DOWN state), then returns to IDLE.
//   undefined - dropping en forces pw_par = 0 on the next edge and returns
//               to IDLE.
//   Fault handling is the same in both builds.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   operator enable (level, already synchronised)
//   fault      in   overcurrent/fault (level, already synchronised)
//   freq_tgt   in   [W]  requested frequency code
//   pw_tgt     in   [W]  requested pulse-width code
//   freq_par   out  [W]  frequency code to the generator (registered)
//   pw_par     out  [W]  pulse-width code to the generator (registered)
//   running    out  high while in RUN
//   locked     out  high while in LOCK
//   dbg_state  out  [3]  current FSM state encoding (IDLE=0, RAMP=1, RUN=2,
//                        LOCK=3, DOWN=4 when the ramp-down build is used)
//
// There is no valid/ready handshake on this block: all inputs are levels
// sampled every clock, all outputs are registered levels.
// ---------------------------------------------------------------------------
module int_seq #(
  parameter int  CLK_MHZ      = 100,
  parameter int  PAR_MAX_VAL  = 255,
  parameter int  PW_MAX       = 200,
  parameter int  RAMP_STEP_US = 100,
  parameter int  LOCK_US      = 10_000,
  localparam int W            = $clog2(PAR_MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         fault,
  input  logic [W-1:0] freq_tgt,
  input  logic [W-1:0] pw_tgt,
  output logic [W-1:0] freq_par,
  output logic [W-1:0] pw_par,
  output logic         running,
  output logic         locked,
  output logic [2:0]   dbg_state
);

  // -------------------------------------------------------------------------
  // Derived timing constants. Both dividers are forced to at least one clock
  // so a degenerate parameter set still produces a working tick / lockout.
  // -------------------------------------------------------------------------
  localparam int RAMP_DIV = (CLK_MHZ * RAMP_STEP_US < 1) ? 1 : CLK_MHZ * RAMP_STEP_US;
  localparam int LOCK_CYC = (CLK_MHZ * LOCK_US < 1) ? 1 : CLK_MHZ * LOCK_US;

  // +1 keeps the widths at least one bit when a divider is 1.
  localparam int DIV_W  = $clog2(RAMP_DIV + 1);
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [W-1:0]      PW_CLAMP  = W'(PW_MAX);
  localparam logic [W-1:0]      PW_ONE    = W'(1);

  // -------------------------------------------------------------------------
  // State encoding. DOWN only exists in the ramp-down build.
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RAMP = 3'd1,
    S_RUN  = 3'd2,
`ifdef INT_SEQ_RAMP_DOWN_EN
    S_LOCK = 3'd3,
    S_DOWN = 3'd4
`else
    S_LOCK = 3'd3
`endif
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic [W-1:0]       r_freq;
  logic [W-1:0]       r_pw;
  logic               r_running;
  logic               r_locked;
  logic [DIV_W-1:0]   r_div;
  logic [LOCK_W-1:0]  r_lock_cnt;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [W-1:0]       w_eff;       // clamped pulse-width target
  logic               w_tick;      // ramp divider terminal count
  logic               w_at_tgt;    // pw_par already equals the target
  logic [W-1:0]       w_pw_step;   // pw_par moved one LSB toward w_eff
  logic               w_pw_zero;
  logic               w_lock_done;
  logic               w_stepping;  // a state in which the ramp divider runs

  assign w_eff       = (pw_tgt > PW_CLAMP) ? PW_CLAMP : pw_tgt;
  assign w_tick      = (r_div == DIV_LAST);
  assign w_at_tgt    = (r_pw == w_eff);
  assign w_pw_zero   = (r_pw == '0);
  assign w_lock_done = (r_lock_cnt == '0);

  // Only consumed when r_pw != w_eff, so the +/-1 can never wrap: moving up
  // stays <= w_eff, moving down stays >= w_eff >= 0.
  assign w_pw_step   = (r_pw < w_eff) ? (r_pw + PW_ONE) : (r_pw - PW_ONE);

`ifdef INT_SEQ_RAMP_DOWN_EN
  assign w_stepping  = (r_state == S_RAMP) || (r_state == S_DOWN);
`else
  assign w_stepping  = (r_state == S_RAMP);
`endif

  // -------------------------------------------------------------------------
  // Sequencer FSM. Fault is evaluated ahead of every state so the generator
  // is muted on the first edge that sees fault, whatever the FSM was doing.
  // running/locked are registered alongside the state so they change on the
  // same edge the state does.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_freq     <= '0;
      r_pw       <= '0;
      r_running  <= 1'b0;
      r_locked   <= 1'b0;
      r_div      <= '0;
      r_lock_cnt <= '0;
    end else begin
      // Frequency code follows the request except while locked out, so the
      // generator restarts on the last frequency it was given.
      if (r_state != S_LOCK) begin
        r_freq <= freq_tgt;
      end

      // Ramp divider free-runs 0..RAMP_DIV-1 while stepping; every entry to
      // RAMP/DOWN below overrides this with a clear.
      if (w_stepping) begin
        r_div <= w_tick ? '0 : (r_div + DIV_ONE);
      end

      if (fault) begin
        r_state    <= S_LOCK;
        r_pw       <= '0;
        r_running  <= 1'b0;
        r_locked   <= 1'b1;
        // Reloaded on every fault cycle, so the minimum lockout is measured
        // from the last cycle fault was seen.
        r_lock_cnt <= LOCK_LAST;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pw <= '0;
            if (en) begin
              r_state <= S_RAMP;
              r_div   <= '0;
            end
          end

          S_RAMP: begin
            if (!en) begin
`ifdef INT_SEQ_RAMP_DOWN_EN
              r_state <= S_DOWN;
              r_div   <= '0;
`else
              r_state <= S_IDLE;
              r_pw    <= '0;
`endif
            end else if (w_at_tgt) begin
              // Covers a zero target too: RUN with pw_par = 0.
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end else if (w_tick) begin
              // w_eff is sampled on the tick cycle itself, so a target change
              // coinciding with a tick steps toward the new value.
              r_pw <= w_pw_step;
            end
          end

          S_RUN: begin
            if (!en) begin
              r_running <= 1'b0;
`ifdef INT_SEQ_RAMP_DOWN_EN
              r_state   <= S_DOWN;
              r_div     <= '0;
`else
              r_state   <= S_IDLE;
              r_pw      <= '0;
`endif
            end else if (!w_at_tgt) begin
              r_state   <= S_RAMP;
              r_running <= 1'b0;
              r_div     <= '0;
            end
          end

`ifdef INT_SEQ_RAMP_DOWN_EN
          S_DOWN: begin
            if (en) begin
              r_state <= S_RAMP;
              r_div   <= '0;
            end else if (w_pw_zero) begin
              r_state <= S_IDLE;
            end else if (w_tick) begin
              r_pw <= r_pw - PW_ONE;
            end
          end
`endif

          S_LOCK: begin
            r_pw <= '0;
            if (!w_lock_done) begin
              r_lock_cnt <= r_lock_cnt - LOCK_ONE;
            end else if (!en) begin
              // Re-arm only after the operator has released en.
              r_state  <= S_IDLE;
              r_locked <= 1'b0;
            end
          end

          default: begin
            r_state   <= S_IDLE;
            r_pw      <= '0;
            r_running <= 1'b0;
            r_locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign freq_par  = r_freq;
  assign pw_par    = r_pw;
  assign running   = r_running;
  assign locked    = r_locked;
  assign dbg_state = r_state;

  // The zero flag is only needed by the ramp-down path.
  logic w_unused;
  assign w_unused = w_pw_zero;

endmodule

// File: tb/tb_int_seq.sv
// ---------------------------------------------------------------------------
// tb_int_seq -- directed bench for int_seq.
// Bench parameters: CLK_MHZ=1, RAMP_STEP_US=4 (RAMP_DIV=4),
// LOCK_US=50 (LOCK_CYC=50), PW_MAX=200, PAR_MAX_VAL=255.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_int_seq;

  localparam int W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RAMP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_LOCK = 3'd3;
  localparam logic [2:0] ST_DOWN = 3'd4;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         fault = 1'b0;
  logic [W-1:0] freq_tgt = '0;
  logic [W-1:0] pw_tgt = '0;
  logic [W-1:0] freq_par;
  logic [W-1:0] pw_par;
  logic         running;
  logic         locked;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  int_seq #(
    .CLK_MHZ      (1),
    .PAR_MAX_VAL  (255),
    .PW_MAX       (200),
    .RAMP_STEP_US (4),
    .LOCK_US      (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fault     (fault),
    .freq_tgt  (freq_tgt),
    .pw_tgt    (pw_tgt),
    .freq_par  (freq_par),
    .pw_par    (pw_par),
    .running   (running),
    .locked    (locked),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_pw, input logic e_run,
                         input logic e_lock, input logic [W-1:0] e_freq, input logic [2:0] e_st);
    chk({tag, ".pw_par"},   32'(pw_par),    32'(e_pw));
    chk({tag, ".running"},  32'(running),   32'(e_run));
    chk({tag, ".locked"},   32'(locked),    32'(e_lock));
    chk({tag, ".freq_par"}, 32'(freq_par),  32'(e_freq));
    chk({tag, ".state"},    32'(dbg_state), 32'(e_st));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic d_en, input logic d_fault,
                       input logic [W-1:0] d_freq, input logic [W-1:0] d_pw);
    en       = d_en;
    fault    = d_fault;
    freq_tgt = d_freq;
    pw_tgt   = d_pw;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic         en;
    logic         fault;
    logic [W-1:0] freq;
    logic [W-1:0] pw;
    int           wait_n;
    logic [W-1:0] exp_pw;
    logic         exp_run;
    logic         exp_lock;
    logic [W-1:0] exp_freq;
    logic [2:0]   exp_st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic a_en, input logic a_fault, input logic [W-1:0] a_freq,
                     input logic [W-1:0] a_pw, input int a_wait, input logic [W-1:0] e_pw,
                     input logic e_run, input logic e_lock, input logic [W-1:0] e_freq,
                     input logic [2:0] e_st);
    vec_t v;
    v.en = a_en; v.fault = a_fault; v.freq = a_freq; v.pw = a_pw; v.wait_n = a_wait;
    v.exp_pw = e_pw; v.exp_run = e_run; v.exp_lock = e_lock; v.exp_freq = e_freq;
    v.exp_st = e_st;
    vq.push_back(v);
  endtask

  // Watchdog: the bench only waits fixed cycle counts, this is a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  initial begin
    // Soft start to 10: steps land 4, 8, ... 40 edges after RAMP entry.
    //    en f   freq   pw    wait  e_pw e_run e_lock e_freq e_state
    add(1, 0, 8'h33,  8'd10,   1,   0,   0, 0, 8'h33, ST_RAMP);
    add(1, 0, 8'h33,  8'd10,   4,   1,   0, 0, 8'h33, ST_RAMP);
    add(1, 0, 8'h33,  8'd10,   3,   1,   0, 0, 8'h33, ST_RAMP);
    add(1, 0, 8'h33,  8'd10,   1,   2,   0, 0, 8'h33, ST_RAMP);
    add(1, 0, 8'h33,  8'd10,  32,  10,   0, 0, 8'h33, ST_RAMP);
    add(1, 0, 8'h33,  8'd10,   1,  10,   1, 0, 8'h33, ST_RUN);
    // Clamp: 250 requested, stops at 200 after 190 steps.
    add(1, 0, 8'h44,  8'd250,  1,  10,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd250,760, 200,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd250,  1, 200,   1, 0, 8'h44, ST_RUN);
    // Target lowered to 150: ramp down, running drops meanwhile.
    add(1, 0, 8'h44,  8'd150,  1, 200,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd150,  4, 199,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd150,196, 150,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd150,  1, 150,   1, 0, 8'h44, ST_RUN);
    // Settle at 100 for the fault test.
    add(1, 0, 8'h44,  8'd100,  1, 150,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd100,200, 100,   0, 0, 8'h44, ST_RAMP);
    add(1, 0, 8'h44,  8'd100,  1, 100,   1, 0, 8'h44, ST_RUN);
    // One-cycle fault from RUN: muted and locked next edge.
    add(1, 1, 8'h44,  8'd100,  1,   0,   0, 1, 8'h44, ST_LOCK);
    // en held high: stays locked well past the minimum; freq_par frozen.
    add(1, 0, 8'h55,  8'd100, 60,   0,   0, 1, 8'h44, ST_LOCK);
    // en dropped with counter expired: IDLE on the next edge.
    add(0, 0, 8'h55,  8'd100,  1,   0,   0, 0, 8'h44, ST_IDLE);
    add(0, 0, 8'h55,  8'd100,  1,   0,   0, 0, 8'h55, ST_IDLE);
    // Fault re-assert at lock cycle 40 reloads the counter: 50 more cycles.
    add(0, 1, 8'h55,  8'd100,  1,   0,   0, 1, 8'h55, ST_LOCK);
    add(0, 0, 8'h66,  8'd100, 39,   0,   0, 1, 8'h55, ST_LOCK);
    add(0, 1, 8'h66,  8'd100,  1,   0,   0, 1, 8'h55, ST_LOCK);
    add(0, 0, 8'h66,  8'd100, 49,   0,   0, 1, 8'h55, ST_LOCK);
    add(0, 0, 8'h66,  8'd100,  1,   0,   0, 0, 8'h55, ST_IDLE);
    add(0, 0, 8'h66,  8'd100,  1,   0,   0, 0, 8'h66, ST_IDLE);

    // Reset: outputs checked while reset is held.
    cycles(2);
    chk_all("reset", 0, 0, 0, 8'h00, ST_IDLE);
    rst_n = 1'b1;
    cycles(2);
    chk_all("post_reset", 0, 0, 0, 8'h00, ST_IDLE);

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].fault, vq[i].freq, vq[i].pw);
      cycles(vq[i].wait_n);
      chk_all($sformatf("v%0d", i), vq[i].exp_pw, vq[i].exp_run, vq[i].exp_lock,
              vq[i].exp_freq, vq[i].exp_st);
    end

    // en drop from pw_par = 8.
    drive(1, 0, 8'h66, 8'd8);
    cycles(1);
    chk_all("drop.ramp", 0, 0, 0, 8'h66, ST_RAMP);
    cycles(32);
    chk_all("drop.at8", 8, 0, 0, 8'h66, ST_RAMP);
    cycles(1);
    chk_all("drop.run", 8, 1, 0, 8'h66, ST_RUN);
    drive(0, 0, 8'h66, 8'd8);
    cycles(1);
`ifdef INT_SEQ_RAMP_DOWN_EN
    chk_all("drop.down0", 8, 0, 0, 8'h66, ST_DOWN);
    cycles(4);
    chk_all("drop.down4", 7, 0, 0, 8'h66, ST_DOWN);
    cycles(28);
    chk_all("drop.down32", 0, 0, 0, 8'h66, ST_DOWN);
    cycles(1);
    chk_all("drop.idle", 0, 0, 0, 8'h66, ST_IDLE);
`else
    chk_all("drop.idle", 0, 0, 0, 8'h66, ST_IDLE);
    cycles(5);
    chk_all("drop.stay", 0, 0, 0, 8'h66, ST_IDLE);
`endif

    // Zero target: RAMP then straight to RUN with pw_par = 0.
    drive(1, 0, 8'h66, 8'd0);
    cycles(1);
    chk_all("zero.ramp", 0, 0, 0, 8'h66, ST_RAMP);
    cycles(1);
    chk_all("zero.run", 0, 1, 0, 8'h66, ST_RUN);
    drive(0, 0, 8'h66, 8'd0);
    cycles(2);
    chk_all("zero.idle", 0, 0, 0, 8'h66, ST_IDLE);

    // en and fault together from IDLE: fault wins.
    drive(1, 1, 8'h66, 8'd10);
    cycles(1);
    chk_all("both.lock", 0, 0, 1, 8'h66, ST_LOCK);
    drive(0, 0, 8'h66, 8'd10);
    cycles(49);
    chk_all("both.hold", 0, 0, 1, 8'h66, ST_LOCK);
    cycles(1);
    chk_all("both.idle", 0, 0, 0, 8'h66, ST_IDLE);

    // Asynchronous reset mid-ramp at pw_par = 5.
    drive(1, 0, 8'h77, 8'd10);
    cycles(1);
    chk_all("ar.ramp", 0, 0, 0, 8'h77, ST_RAMP);
    cycles(20);
    chk_all("ar.at5", 5, 0, 0, 8'h77, ST_RAMP);
    #2 rst_n = 1'b0;
    #1;
    chk_all("ar.async", 0, 0, 0, 8'h00, ST_IDLE);
    @(negedge clk);
    drive(0, 0, 8'h77, 8'd10);
    rst_n = 1'b1;
    cycles(3);
    chk_all("ar.idle", 0, 0, 0, 8'h77, ST_IDLE);
    drive(1, 0, 8'h77, 8'd10);
    cycles(1);
    chk_all("ar.rearm", 0, 0, 0, 8'h77, ST_RAMP);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
